// File: rtl/sprite_render_ctrl.sv
// Sprite renderer: erases, repositions and redraws a ROM-backed sprite one pixel per cycle.
// Pixel outputs are registered, so index i issued in cycle k is presented in cycle k+1.
module sprite_render_ctrl #(
    parameter int SPR_W    = 16,
    parameter int SPR_H    = 16,
    parameter int COLOUR_W = 12,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119,
    parameter int START_X  = 49,
    parameter int START_Y  = 48,
    parameter int STEP_W   = 4,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = 12'h000,
    parameter logic [COLOUR_W-1:0] BG_COLOUR   = 12'h000
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 go,
    input  logic [1:0]                           mode,
    input  logic [STEP_W-1:0]                    dx,
    input  logic [STEP_W-1:0]                    dy,
    input  logic [X_W-1:0]                       load_x,
    input  logic [Y_W-1:0]                       load_y,
    output logic [$clog2(SPR_W*SPR_H)-1:0]       rom_addr,
    input  logic [COLOUR_W-1:0]                  rom_data,
    output logic [X_W-1:0]                       x_out,
    output logic [Y_W-1:0]                       y_out,
    output logic [COLOUR_W-1:0]                  colour_out,
    output logic                                 plot,
    output logic                                 busy,
    output logic                                 done,
    output logic [X_W-1:0]                       posx,
    output logic [Y_W-1:0]                       posy
);

    localparam int unsigned N  = SPR_W * SPR_H;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned CW = $clog2(SPR_W);

    localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX - SPR_W + 1);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX - SPR_H + 1);
    localparam logic [X_W:0]   X_VIS = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0]   Y_VIS = (Y_W+1)'(Y_MAX);
    localparam logic [AW:0]    LAST  = (AW+1)'(N);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] UPDATE = 3'd2;
    localparam logic [2:0] DRAW   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [1:0] M_DRAW  = 2'b00;
    localparam logic [1:0] M_CLEAR = 2'b01;
    localparam logic [1:0] M_LOAD  = 2'b11;

    logic [2:0]        state;
    logic [AW:0]       idx;
    logic [1:0]        mode_l;
    logic [STEP_W-1:0] dx_l, dy_l;
    logic [X_W-1:0]    lx_l, new_x;
    logic [Y_W-1:0]    ly_l, new_y;
    logic [X_W+1:0]    sum_x;
    logic [Y_W+1:0]    sum_y;
    logic [X_W:0]      pix_x;
    logic [Y_W:0]      pix_y;
    logic              draw_phase, pix_active, pix_vis;

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign rom_addr = idx[AW-1:0];

    always_comb begin
        draw_phase = (state == DRAW);
        // idx == LAST is the drain cycle: nothing issued, last pixel still on the outputs
        pix_active = ((state == CLEAR) || draw_phase) && (idx != LAST);
        pix_x      = {1'b0, posx} + (X_W+1)'(idx[CW-1:0]);
        pix_y      = {1'b0, posy} + (Y_W+1)'(idx[AW-1:CW]);
        pix_vis    = (pix_x <= X_VIS) && (pix_y <= Y_VIS) &&
                     !(draw_phase && (rom_data == TRANSPARENT));
    end

    always_comb begin
        // Bit [W+1] of the extended sum is the sign of pos+step
        sum_x = {2'b00, posx} + {{(X_W+2-STEP_W){dx_l[STEP_W-1]}}, dx_l};
        sum_y = {2'b00, posy} + {{(Y_W+2-STEP_W){dy_l[STEP_W-1]}}, dy_l};
        new_x = posx;
        new_y = posy;
        if (mode_l == M_LOAD) begin
            new_x = (lx_l > X_LIM) ? X_LIM : lx_l;
            new_y = (ly_l > Y_LIM) ? Y_LIM : ly_l;
        end else begin
            if (sum_x[X_W+1])                     new_x = '0;
            else if (sum_x[X_W:0] > {1'b0, X_LIM}) new_x = X_LIM;
            else                                  new_x = sum_x[X_W-1:0];
            if (sum_y[Y_W+1])                     new_y = '0;
            else if (sum_y[Y_W:0] > {1'b0, Y_LIM}) new_y = Y_LIM;
            else                                  new_y = sum_y[Y_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            mode_l <= '0;
            dx_l   <= '0;
            dy_l   <= '0;
            lx_l   <= '0;
            ly_l   <= '0;
            posx   <= X_W'(START_X);
            posy   <= Y_W'(START_Y);
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        mode_l <= mode;
                        dx_l   <= dx;
                        dy_l   <= dy;
                        lx_l   <= load_x;
                        ly_l   <= load_y;
                        idx    <= '0;
                        state  <= (mode == M_DRAW) ? DRAW : CLEAR;
                    end
                end
                CLEAR: begin
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= (mode_l == M_CLEAR) ? DONE : UPDATE;
                    end else begin
                        idx <= idx + (AW+1)'(1);
                    end
                end
                UPDATE: begin
                    posx  <= new_x;
                    posy  <= new_y;
                    state <= DRAW;
                end
                DRAW: begin
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + (AW+1)'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
        end else if (pix_active) begin
            x_out      <= pix_x[X_W-1:0];
            y_out      <= pix_y[Y_W-1:0];
            colour_out <= draw_phase ? rom_data : BG_COLOUR;
            plot       <= pix_vis;
        end else begin
            plot <= 1'b0;
        end
    end

endmodule
